// File: rtl/led_strip_pkg.sv
// Shared types and default timing for the LED strip serializer.
package led_strip_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, LATCH} state_t;
    typedef logic [23:0] pixel_t;  // {G[7:0], R[7:0], B[7:0]}

    localparam int LED_ADDR_W           = 10;
    localparam int DEF_LED_COUNT        = 237;
    localparam int DEF_T0H              = 35;
    localparam int DEF_T1H              = 70;
    localparam int DEF_TBIT             = 125;
    localparam int DEF_LATCH_CYCLES     = 5000;
endpackage

// File: rtl/led_bit_encoder.sv
// One-wire bit encoder: a load starts a TBIT-cycle period whose high time
// depends on the bit value; bit_end flags the final cycle of the period.
module led_bit_encoder #(
    parameter int T0H  = 35,
    parameter int T1H  = 70,
    parameter int TBIT = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic bit_val,
    output logic led,
    output logic bit_end
);
    localparam int CW = $clog2(TBIT);

    logic [CW-1:0] cnt;
    logic          cur_bit;
    logic          active;

    always_comb bit_end = active && (cnt == CW'(TBIT - 1));

    // led is registered, so it is computed from the counter value of the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            cur_bit <= 1'b0;
            active  <= 1'b0;
            led     <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            cur_bit <= bit_val;
            active  <= 1'b1;
            led     <= 1'b1;
        end else if (bit_end) begin
            cnt    <= '0;
            active <= 1'b0;
            led    <= 1'b0;
        end else if (active) begin
            cnt <= cnt + 1'b1;
            led <= (int'(cnt) + 1 < (cur_bit ? T1H : T0H));
        end
    end
endmodule

// File: rtl/led_strip_tx.sv
// LED strip frame serializer: fetches GRB words from pixel RAM and drives the
// one-wire data line. Define LED_STRIP_TX_AUTO_REFRESH_EN for continuous refresh.
module led_strip_tx
    import led_strip_pkg::*;
#(
    parameter int LED_COUNT    = DEF_LED_COUNT,
    parameter int T0H          = DEF_T0H,
    parameter int T1H          = DEF_T1H,
    parameter int TBIT         = DEF_TBIT,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic                  pixel_clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LED_ADDR_W-1:0] ram_addr_o,
    output logic                  ram_rd_o,
    input  pixel_t                ram_data_i,
    output logic                  led_data_o
);
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    state_t                state;
    pixel_t                sreg;
    pixel_t                next_word;
    logic [LED_ADDR_W-1:0] pix_idx;
    logic [4:0]            bit_idx;
    logic [LW-1:0]         latch_cnt;
    logic                  rd_q;
    logic                  last_pixel;
    logic                  enc_load;
    logic                  enc_bit;
    logic                  enc_end;

    always_comb last_pixel = (pix_idx == LED_ADDR_W'(LED_COUNT - 1));

    // sreg is kept pre-shifted: its MSB is always the next bit to hand to the encoder.
    always_comb begin
        enc_load = 1'b0;
        enc_bit  = 1'b0;
        case (state)
            WAIT: begin
                enc_load = 1'b1;
                enc_bit  = ram_data_i[23];
            end
            SHIFT: begin
                if (enc_end) begin
                    if (bit_idx != '0) begin
                        enc_load = 1'b1;
                        enc_bit  = sreg[23];
                    end else if (!last_pixel) begin
                        enc_load = 1'b1;
                        enc_bit  = next_word[23];
                    end
                end
            end
            default: ;
        endcase
    end

    led_bit_encoder #(
        .T0H (T0H),
        .T1H (T1H),
        .TBIT(TBIT)
    ) u_enc (
        .clk    (pixel_clk_i),
        .reset  (reset_i),
        .load   (enc_load),
        .bit_val(enc_bit),
        .led    (led_data_o),
        .bit_end(enc_end)
    );

    always_ff @(posedge pixel_clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            sreg       <= '0;
            next_word  <= '0;
            pix_idx    <= '0;
            bit_idx    <= '0;
            latch_cnt  <= '0;
            rd_q       <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            ram_addr_o <= '0;
            ram_rd_o   <= 1'b0;
        end else begin
            rd_q     <= ram_rd_o;
            ram_rd_o <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= FETCH;
                        busy_o     <= 1'b1;
                        ram_addr_o <= '0;
                        ram_rd_o   <= 1'b1;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    sreg    <= {ram_data_i[22:0], 1'b0};
                    pix_idx <= '0;
                    bit_idx <= 5'd23;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (rd_q) next_word <= ram_data_i;
                    if (enc_end) begin
                        if (bit_idx != '0) begin
                            sreg    <= sreg << 1;
                            bit_idx <= bit_idx - 1'b1;
                            // Bit 0 is about to start: prefetch the next pixel during its first cycle.
                            if (bit_idx == 5'd1 && !last_pixel) begin
                                ram_addr_o <= pix_idx + 1'b1;
                                ram_rd_o   <= 1'b1;
                            end
                        end else if (last_pixel) begin
                            state     <= LATCH;
                            latch_cnt <= '0;
                            done_o    <= (LATCH_CYCLES == 1);
                        end else begin
                            sreg    <= {next_word[22:0], 1'b0};
                            pix_idx <= pix_idx + 1'b1;
                            bit_idx <= 5'd23;
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt == LW'(LATCH_CYCLES - 1)) begin
                        latch_cnt <= '0;
`ifdef LED_STRIP_TX_AUTO_REFRESH_EN
                        state      <= FETCH;
                        ram_addr_o <= '0;
                        ram_rd_o   <= 1'b1;
`else
                        state  <= IDLE;
                        busy_o <= 1'b0;
`endif
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                        done_o    <= (int'(latch_cnt) + 1 == LATCH_CYCLES - 1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/led_strip_tx.md
Name: led_strip_tx

Overview:
Reads LED colours from the LED strip pixel RAM, which the wall edge mappers fill. Serializes them onto one WS2812-style one-wire data line.
Per frame: walks addresses 0..LED_COUNT-1, sends 24 bits per LED in GRB order, MSB first, then holds the line low for the latch period.
Sits between the LED strip RAM read port and the cape's LED data output pin.

Parameters:
LED_COUNT, 237, LEDs per frame; 1..1024.
T0H, 35, high time of a '0' bit, in pixel_clk_i cycles.
T1H, 70, high time of a '1' bit, in cycles.
TBIT, 125, total bit period, in cycles; requires 0 < T0H < T1H < TBIT and TBIT >= 4.
LATCH_CYCLES, 5000, low time after the last bit, in cycles.

Ports:
pixel_clk_i  in  1  sole clock; all logic on its rising edge.
reset_i  in  1  synchronous, active-high reset.
start_i  in  1  one-cycle pulse that requests a frame; sampled only in IDLE.
busy_o  out  1  high from the cycle after start is accepted until the return to IDLE.
done_o  out  1  one-cycle pulse in the last LATCH cycle.
ram_addr_o  out  10  LED strip RAM read address.
ram_rd_o  out  1  read strobe.
ram_data_i  in  24  {G[7:0],R[7:0],B[7:0]}; valid exactly 1 cycle after ram_rd_o.
led_data_o  out  1  serial LED data line.

Behaviour:
- Reset values:
  - led_data_o=0, busy_o=0, done_o=0, ram_rd_o=0, ram_addr_o=0.
  - State=IDLE; all counters cleared.
- Reset mid-frame: aborts immediately. Next cycle the outputs hold reset values; no partial-frame completion.
- FSM states: IDLE, FETCH, WAIT, SHIFT, LATCH.
- IDLE:
  - start_i=1 -> FETCH, busy_o=1.
  - start_i while not IDLE is ignored; no queuing.
- FETCH (1 cycle): ram_addr_o=0, ram_rd_o=1 -> WAIT.
- WAIT (1 cycle): latch ram_data_i into the shift register; pixel index=0, bit=23 -> SHIFT.
- SHIFT:
  - Bit-cycle counter runs 0..TBIT-1.
  - led_data_o=1 while counter < (current bit ? T1H : T0H), else 0.
  - At counter=TBIT-1: shift left one and decrement the bit count.
- Prefetch:
  - In counter=0 of bit 0 of pixel n, with n < LED_COUNT-1: ram_addr_o=n+1, ram_rd_o=1.
  - Next cycle, ram_data_i is captured into the next-word register.
  - At the end of bit 0, the shift register loads the next word. The bit stream is gap-free across pixels.
- End of bit 0 of pixel LED_COUNT-1 -> LATCH; led_data_o=0.
- LATCH:
  - Counter runs 0..LATCH_CYCLES-1.
  - done_o=1 in the last cycle -> IDLE; busy_o=0 in the following cycle.
- ram_rd_o is high only in FETCH and the prefetch cycle. ram_addr_o holds its last value otherwise.
- Frame length from accepted start to done_o inclusive: 2 + 24*LED_COUNT*TBIT + LATCH_CYCLES cycles.
- Counter widths: bit counter 5b; pixel index 10b; bit-period counter $clog2(TBIT); latch counter $clog2(LATCH_CYCLES).
- LED_COUNT=1: no prefetch is issued. LATCH follows directly after pixel 0.

Optional Feature:
LED_STRIP_TX_AUTO_REFRESH_EN.
- Defined: after LATCH the FSM goes directly to FETCH. It refreshes continuously without start_i, and busy_o stays 1. done_o still pulses once per frame. The first frame after reset still waits for start_i.
- Undefined: behaviour as above; frames only on start_i.

Decomposition:
- Shared package led_strip_pkg holds:
  - FSM state enum;
  - pixel word typedef (24b GRB);
  - LED_ADDR_W=10;
  - default timing constants.
- Sub-module led_bit_encoder takes bit value and a load strobe, and produces the timed high/low waveform plus an end-of-bit strobe. The top FSM handles fetch/prefetch and the frame sequence.

Test Plan:
- Reset, then idle 100 cycles -> led_data_o=0, busy_o=0, no ram_rd_o.
- Single-LED timing: LED_COUNT=1, RAM[0]=24'hA50F00, start pulse.
  - Bit 23 ('1') high 70 cycles, low 55; bit 22 ('0') high 35, low 90.
  - All 24 bits match the word.
  - done_o after 2+3000+5000 cycles.
- Multi-pixel continuity: LED_COUNT=3, RAM={24'hFFFFFF,24'h000000,24'h800001}.
  - Exactly one read per address, in order 0,1,2.
  - No gap or extended pulse at the pixel 0->1 and 1->2 boundaries.
  - Decoded stream equals the RAM contents.
- start_i pulsed mid-frame -> ignored; the frame ends at the nominal cycle with exactly one done_o.
- reset_i asserted during bit 10 of pixel 1 -> next cycle led_data_o=0, busy_o=0. A new start produces a full frame beginning at address 0.
- With LED_STRIP_TX_AUTO_REFRESH_EN: single start -> three consecutive frames.
  - done_o spaced exactly 2+24*LED_COUNT*TBIT+LATCH_CYCLES apart.
  - busy_o constantly 1.
